// File: rtl/reg_writeback_ctrl.sv
// Writeback controller: ALU/LSU result FIFOs onto one register-file write port
// with a busy scoreboard. Define WB_RR_ARB_EN for round-robin arbitration.
module reg_writeback_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic [4:0]  w_reg,
  output logic [31:0] w_data,
  output logic        Reg_Write,
  input  logic [4:0]  chk_reg1,
  input  logic [4:0]  chk_reg2,
  output logic        hazard1,
  output logic        hazard2
);

  // Channel index 0 is ALU, 1 is LSU; entries are {rd, data}.
  logic [36:0] mem_q [2][2];
  logic [36:0] mem_d [2][2];
  logic [1:0]  cnt_q [2];
  logic [1:0]  cnt_d [2];
  logic        wp_q  [2];
  logic        wp_d  [2];
  logic        rp_q  [2];
  logic        rp_d  [2];

  logic [31:1] busy_q;
  logic [31:1] busy_d;
  logic        reg_write_q;
  logic        reg_write_d;
  logic [4:0]  w_reg_q;
  logic [4:0]  w_reg_d;
  logic [31:0] w_data_q;
  logic [31:0] w_data_d;
`ifdef WB_RR_ARB_EN
  logic        rr_q;
  logic        rr_d;
`endif

  logic [1:0]  in_valid;
  logic [4:0]  in_rd   [2];
  logic [31:0] in_data [2];
  logic [1:0]  ne;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic [36:0] head;
  logic [31:0] busy_ext;

  assign alu_ready = rst_n & (cnt_q[0] != 2'd2);
  assign lsu_ready = rst_n & (cnt_q[1] != 2'd2);

  assign busy_ext = {busy_q, 1'b0};
  assign hazard1  = busy_ext[chk_reg1];
  assign hazard2  = busy_ext[chk_reg2];

  assign Reg_Write = reg_write_q;
  assign w_reg     = w_reg_q;
  assign w_data    = w_data_q;

  always_comb begin
    in_valid   = {lsu_valid, alu_valid};
    in_rd[0]   = alu_rd;
    in_rd[1]   = lsu_rd;
    in_data[0] = alu_data;
    in_data[1] = lsu_data;
    for (int c = 0; c < 2; c++) begin
      ne[c]   = cnt_q[c] != 2'd0;
      push[c] = in_valid[c] && (cnt_q[c] != 2'd2)
                && (in_rd[c] != 5'd0);
    end

    pop = 2'b00;
`ifdef WB_RR_ARB_EN
    rr_d = rr_q;
`endif
    unique case (1'b1)
      ne[0] && ne[1]: begin
`ifdef WB_RR_ARB_EN
        pop  = rr_q ? 2'b01 : 2'b10;
        rr_d = ~rr_q;
`else
        pop  = 2'b10;
`endif
      end
      default: pop = ne;
    endcase

    head = pop[1] ? mem_q[1][rp_q[1]] : mem_q[0][rp_q[0]];

    mem_d = mem_q;
    for (int c = 0; c < 2; c++) begin
      cnt_d[c] = cnt_q[c] + {1'b0, push[c]} - {1'b0, pop[c]};
      wp_d[c]  = wp_q[c] ^ push[c];
      rp_d[c]  = rp_q[c] ^ pop[c];
      if (push[c])
        mem_d[c][wp_q[c]] = {in_rd[c], in_data[c]};
    end

    reg_write_d = |pop;
    w_reg_d     = w_reg_q;
    w_data_d    = w_data_q;
    if (|pop) begin
      w_reg_d  = head[36:32];
      w_data_d = head[31:0];
    end

    // A new issue to the same register outranks the clearing pop.
    for (int i = 1; i < 32; i++) begin
      busy_d[i] = (busy_q[i] & ~(|pop && head[36:32] == 5'(i)))
                | (iss_valid && iss_rd == 5'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q       <= '{default: '0};
      cnt_q       <= '{default: '0};
      wp_q        <= '{default: '0};
      rp_q        <= '{default: '0};
      busy_q      <= '0;
      reg_write_q <= 1'b0;
      w_reg_q     <= '0;
      w_data_q    <= '0;
`ifdef WB_RR_ARB_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      mem_q       <= mem_d;
      cnt_q       <= cnt_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      busy_q      <= busy_d;
      reg_write_q <= reg_write_d;
      w_reg_q     <= w_reg_d;
      w_data_q    <= w_data_d;
`ifdef WB_RR_ARB_EN
      rr_q        <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: vector table, corner sequences and a
// queue-based reference model under random traffic.
module tb_reg_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [4:0]  w_reg;
  logic [31:0] w_data;
  logic        Reg_Write;
  logic [4:0]  chk_reg1;
  logic [4:0]  chk_reg2;
  logic        hazard1;
  logic        hazard2;

  reg_writeback_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .w_reg(w_reg), .w_data(w_data), .Reg_Write(Reg_Write),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .hazard1(hazard1), .hazard2(hazard2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  ird;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        ea;
    logic        el;
    logic        eh1;
    logic        eh2;
    logic        erw;
    logic [4:0]  ewr;
    logic [31:0] ewd;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        aq[$];
  ent_t        lq[$];
  bit          busy_m [32];
  bit          m_rr;
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  int          checks = 0;
  int          errors = 0;
  bit          a_acc = 0;
  bit          l_acc = 0;
  int          wlog[$];
  vec_t        tab [17];
  vec_t        dv;

  function automatic vec_t V(
    input logic r, iv, input logic [4:0] ird,
    input logic av, input logic [4:0] ard,
    input logic [31:0] ad,
    input logic lv, input logic [4:0] lrd,
    input logic [31:0] ld,
    input logic [4:0] c1, c2,
    input logic ea, el, eh1, eh2, erw,
    input logic [4:0] ewr, input logic [31:0] ewd);
    vec_t v;
    v.rst = r;  v.iv = iv;   v.ird = ird;
    v.av = av;  v.ard = ard; v.ad = ad;
    v.lv = lv;  v.lrd = lrd; v.ld = ld;
    v.c1 = c1;  v.c2 = c2;
    v.ea = ea;  v.el = el;
    v.eh1 = eh1; v.eh2 = eh2;
    v.erw = erw; v.ewr = ewr; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h",
               nm, $time, act, exp);
    end
  endtask

  task automatic mreset();
    aq.delete();
    lq.delete();
    foreach (busy_m[i]) busy_m[i] = 0;
    m_rr = 0;
    m_rw = 0;
    m_wr = '0;
    m_wd = '0;
  endtask

  task automatic set_in(input vec_t v);
    rst_n     = v.rst;
    iss_valid = v.iv;
    iss_rd    = v.ird;
    alu_valid = v.av;
    alu_rd    = v.ard;
    alu_data  = v.ad;
    lsu_valid = v.lv;
    lsu_rd    = v.lrd;
    lsu_data  = v.ld;
    chk_reg1  = v.c1;
    chk_reg2  = v.c2;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic cycle(input bit use_tab, input vec_t v);
    bit   ea, el, eh1, eh2, na, nl, take_l;
    ent_t e;
    #1;
    ea  = rst_n && (aq.size() < 2);
    el  = rst_n && (lq.size() < 2);
    eh1 = (chk_reg1 != 0) && busy_m[chk_reg1];
    eh2 = (chk_reg2 != 0) && busy_m[chk_reg2];
    chk("alu_ready", alu_ready, ea);
    chk("lsu_ready", lsu_ready, el);
    chk("hazard1", hazard1, eh1);
    chk("hazard2", hazard2, eh2);
    if (use_tab) begin
      chk("tab_alu_ready", alu_ready, v.ea);
      chk("tab_lsu_ready", lsu_ready, v.el);
      chk("tab_hazard1", hazard1, v.eh1);
      chk("tab_hazard2", hazard2, v.eh2);
    end
    a_acc = alu_valid && ea;
    l_acc = lsu_valid && el;
    if (!rst_n) begin
      mreset();
    end else begin
      na = aq.size() > 0;
      nl = lq.size() > 0;
      if (na || nl) begin
        if (na && nl) begin
`ifdef WB_RR_ARB_EN
          take_l = !m_rr;
          m_rr   = !m_rr;
`else
          take_l = 1;
`endif
        end else begin
          take_l = nl;
        end
        if (take_l) e = lq.pop_front();
        else        e = aq.pop_front();
        busy_m[e.rd] = 0;
        m_rw = 1;
        m_wr = e.rd;
        m_wd = e.d;
      end else begin
        m_rw = 0;
      end
      if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1;
      if (a_acc && alu_rd != 0) aq.push_back('{alu_rd, alu_data});
      if (l_acc && lsu_rd != 0) lq.push_back('{lsu_rd, lsu_data});
    end
    @(posedge clk);
    #1;
    chk("Reg_Write", Reg_Write, m_rw);
    chk("w_reg", w_reg, m_wr);
    chk("w_data", w_data, m_wd);
    if (use_tab) begin
      chk("tab_Reg_Write", Reg_Write, v.erw);
      chk("tab_w_reg", w_reg, v.ewr);
      chk("tab_w_data", w_data, v.ewd);
    end
    if (Reg_Write === 1'b1) wlog.push_back(int'(w_reg));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   exp_ord [4];
    int   ai, li;
    bit   full_seen;
    dv = V(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);

    tab[0]  = V(0, 0,0, 0,0,0, 0,0,0, 0,0,
                0,0,0,0, 0,0,0);
    tab[1]  = V(1, 1,5, 1,5,32'h0011_1334, 0,0,0, 5,0,
                1,1,0,0, 0,0,0);
    tab[2]  = V(1, 0,0, 0,0,0, 0,0,0, 5,0,
                1,1,1,0, 1,5,32'h0011_1334);
    tab[3]  = V(1, 0,0, 0,0,0, 0,0,0, 5,0,
                1,1,0,0, 0,5,32'h0011_1334);
    tab[4]  = V(1, 1,7, 0,0,0, 0,0,0, 7,0,
                1,1,0,0, 0,5,32'h0011_1334);
    tab[5]  = V(1, 0,0, 0,0,0, 1,7,32'hA5A5_0007, 7,0,
                1,1,1,0, 0,5,32'h0011_1334);
    tab[6]  = V(1, 0,0, 0,0,0, 0,0,0, 7,0,
                1,1,1,0, 1,7,32'hA5A5_0007);
    tab[7]  = V(1, 0,0, 0,0,0, 0,0,0, 7,0,
                1,1,0,0, 0,7,32'hA5A5_0007);
    tab[8]  = V(1, 0,0, 1,0,32'hFFFF_FFFF, 0,0,0, 0,0,
                1,1,0,0, 0,7,32'hA5A5_0007);
    tab[9]  = V(1, 0,0, 0,0,0, 0,0,0, 0,0,
                1,1,0,0, 0,7,32'hA5A5_0007);
    tab[10] = V(1, 1,9, 0,0,0, 1,9,32'h0000_0909, 0,9,
                1,1,0,0, 0,7,32'hA5A5_0007);
    tab[11] = V(1, 1,9, 0,0,0, 0,0,0, 0,9,
                1,1,0,1, 1,9,32'h0000_0909);
    tab[12] = V(1, 0,0, 0,0,0, 0,0,0, 0,9,
                1,1,0,1, 0,9,32'h0000_0909);
    tab[13] = V(1, 0,0, 1,3,32'h33, 1,4,32'h44, 0,9,
                1,1,0,1, 0,9,32'h0000_0909);
    tab[14] = V(0, 0,0, 0,0,0, 0,0,0, 0,9,
                0,0,0,1, 0,0,0);
    tab[15] = V(1, 0,0, 0,0,0, 0,0,0, 0,9,
                1,1,0,0, 0,0,0);
    tab[16] = V(1, 0,0, 0,0,0, 0,0,0, 0,0,
                1,1,0,0, 0,0,0);

    set_in(dv);
    mreset();
    @(posedge clk);
    #1;

    foreach (tab[i]) begin
      set_in(tab[i]);
      cycle(1, tab[i]);
    end

    // Both channels loaded back to back, then drained.
    set_in(dv);
    cycle(0, dv);
    wlog.delete();
    rst_n = 1;
    alu_valid = 1; alu_rd = 21; alu_data = 32'hA21;
    lsu_valid = 1; lsu_rd = 11; lsu_data = 32'hB11;
    cycle(0, dv);
    alu_rd = 22; alu_data = 32'hA22;
    lsu_rd = 12; lsu_data = 32'hB12;
    cycle(0, dv);
    alu_valid = 0;
    lsu_valid = 0;
    for (int k = 0; k < 5; k++) cycle(0, dv);
`ifdef WB_RR_ARB_EN
    exp_ord = '{11, 21, 12, 22};
`else
    exp_ord = '{11, 12, 21, 22};
`endif
    chk("order_len", 32'(wlog.size()), 32'd4);
    for (int k = 0; k < 4 && k < wlog.size(); k++)
      chk("write_order", 32'(wlog[k]), 32'(exp_ord[k]));

    // ALU held valid for three entries while LSU competes for the port.
    set_in(dv);
    cycle(0, dv);
    rst_n = 1;
    ai = 0;
    li = 0;
    full_seen = 0;
    for (int k = 0; k < 12; k++) begin
      alu_valid = ai < 3;
      alu_rd    = 5'(1 + ai);
      alu_data  = 32'h100 + 32'(ai);
      lsu_valid = li < 3;
      lsu_rd    = 5'(4 + li);
      lsu_data  = 32'h200 + 32'(li);
      cycle(0, dv);
      if (a_acc) ai++;
      if (l_acc) li++;
      if (alu_ready === 1'b0) full_seen = 1;
    end
    chk("alu_fill_backpressure", 32'(full_seen), 32'd1);
    chk("alu_all_accepted", 32'(ai), 32'd3);

    // Random traffic against the reference model.
    set_in(dv);
    rst_n = 1;
    a_acc = 0;
    l_acc = 0;
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom % 250) != 0;
      if (!(alu_valid && !a_acc)) begin
        alu_valid = $urandom % 2;
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!(lsu_valid && !l_acc)) begin
        lsu_valid = $urandom % 2;
        lsu_rd    = 5'($urandom_range(0, 7));
        lsu_data  = $urandom;
      end
      iss_valid = ($urandom % 3) == 0;
      iss_rd    = 5'($urandom_range(0, 7));
      chk_reg1  = 5'($urandom_range(0, 7));
      chk_reg2  = 5'($urandom_range(0, 7));
      cycle(0, dv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback_ctrl.md
REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

Interface
REQ-001 SHALL have ports clk (in, 1, rising-edge clock) and rst_n (in, 1, synchronous active-low reset); one clock, reset synchronous and active-low.
REQ-002 SHALL have iss_valid (in, 1) and iss_rd (in, 5): destination reservation at instruction issue.
REQ-003 SHALL have alu_valid (in, 1), alu_ready (out, 1), alu_rd (in, 5), alu_data (in, 32): ALU result channel.
REQ-004 SHALL have lsu_valid (in, 1), lsu_ready (out, 1), lsu_rd (in, 5), lsu_data (in, 32): load result channel.
REQ-005 SHALL have w_reg (out, 5), w_data (out, 32), Reg_Write (out, 1): register-file write port, all registered.
REQ-006 SHALL have chk_reg1 and chk_reg2 (in, 5) and hazard1 and hazard2 (out, 1): operand hazard query for both read ports.

Function
REQ-007 Transfer on a channel SHALL occur at a rising edge where valid and ready are both high; data is held stable by the source while valid is high and ready is low.
REQ-008 Each channel SHALL own a 2-entry FIFO; ready = FIFO not full, combinational from FIFO state only, never from valid.
REQ-009 Transfers with rd = 0 SHALL be accepted and discarded (not enqueued); Reg_Write SHALL never assert with w_reg = 0.
REQ-010 At each edge where at least one FIFO is non-empty, exactly one head SHALL be popped into the output register; Reg_Write is high for exactly the following cycle per pop.
REQ-011 Latency SHALL be 2 cycles minimum: transfer at edge E0, pop at E1, Reg_Write/w_reg/w_data valid in the cycle after E1.
REQ-012 A FIFO that is full SHALL accept a new transfer at the same edge it is popped only if ready was high beforehand; ready is not raised combinationally by a same-cycle pop.
REQ-013 When Reg_Write is low, w_reg and w_data SHALL hold their last values.
REQ-014 A 31-bit busy vector (registers 1..31) SHALL be set at the edge where iss_valid is high and iss_rd != 0.
REQ-015 The busy bit of a register SHALL clear at the pop edge that writes it (E1).
REQ-016 Simultaneous set and clear of the same busy bit SHALL leave it set (new producer wins).
REQ-017 hazardN SHALL equal busy[chk_regN], combinational; chk_regN = 0 SHALL always give 0.
REQ-018 Writes to a non-busy register SHALL still be performed; they have no busy-vector effect.
REQ-019 Within a channel, writes SHALL reach the port in acceptance order; no ordering is guaranteed across channels.

Reset
REQ-020 While rst_n is low at an edge: both FIFOs empty, busy vector all 0, Reg_Write = 0, w_reg = 0, w_data = 0, round-robin pointer = LSU-first.
REQ-021 alu_ready and lsu_ready SHALL be 0 in any cycle where rst_n is low, and 1 in the first cycle after reset deasserts.
REQ-022 Reset mid-operation SHALL drop all queued writes without asserting Reg_Write for them.

Configuration
REQ-023 Macro WB_RR_ARB_EN defined: when both FIFOs are non-empty, the grant SHALL alternate; the pointer toggles only on a contested pop.
REQ-024 WB_RR_ARB_EN undefined: the LSU head SHALL always win when both FIFOs are non-empty; port list is identical in both builds.

Verification
REQ-025 Reset then single ALU transfer rd=5, data=32'h0011_1334 at E0 -> Reg_Write=1, w_reg=5, w_data=32'h0011_1334 in the cycle after E1 only; busy[5] cleared if previously set.
REQ-026 iss_valid with iss_rd=7, then chk_reg1=7 -> hazard1=1 until the LSU write to rd 7 pops; hazard1=0 from the following cycle.
REQ-027 Hold alu_valid high with 3 back-to-back entries and no pops possible -> alu_ready=0 after 2 accepted; third accepted only after a pop.
REQ-028 Both channels hold 2 entries -> with WB_RR_ARB_EN, write order is LSU, ALU, LSU, ALU; without it, order is LSU, LSU, ALU, ALU.
REQ-029 ALU transfer with rd=0, data=32'hFFFF_FFFF -> no Reg_Write pulse; alu_ready unaffected; chk_reg1=0 -> hazard1=0.
REQ-030 Issue rd=9 at the same edge that a queued write to rd 9 pops -> busy[9] stays 1; rst_n low with entries queued -> no Reg_Write afterwards, all busy bits 0.
